// File: rtl/rand_sched_pkg.sv
// Shared types and helpers for the constrained-random request scheduler:
// FSM state encoding, the signed value type and the range/PRNG functions.
package rand_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAND = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic signed [31:0] val_t;

    localparam int DEFAULT_MAX_RETRY = 3;

    localparam logic [31:0] RNG_SEED = 32'h2545_F491;

    function automatic int id_w(input int n);
        int w;
        w = $clog2(n);
        id_w = (w < 1) ? 1 : w;
    endfunction

    // Smallest all-ones mask that covers span_m1, so (rnd & mask) needs at
    // most one subtraction to fold back into [0, span_m1].
    function automatic logic [31:0] span_mask(input logic [31:0] span_m1);
        logic [31:0] m;
        m = span_m1;
        m = m | (m >> 5'd1);
        m = m | (m >> 5'd2);
        m = m | (m >> 5'd4);
        m = m | (m >> 5'd8);
        m = m | (m >> 5'd16);
        return m;
    endfunction

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 5'd13);
        y = y ^ (y >> 5'd17);
        y = y ^ (y << 5'd5);
        return y;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above
// ptr, wrapping around, whenever enable is high.
module rr_arbiter
    import rand_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int W = id_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         enable,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    logic         found_s;
    logic [W-1:0] pos_s;

    // Priority search rotated to start at ptr.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int i = 0; i < N; i++) begin
            pos_s = W'((int'(ptr) + i) % N);
            if (enable && !found_s && req[pos_s]) begin
                found_s      = 1'b1;
                grant[pos_s] = 1'b1;
                idx          = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rand_req_sched.sv
// Round-robin constrained-random value server: one randomize attempt per cycle
// on latched (lo, hi] bounds, results returned over a valid/ready channel.
module rand_req_sched
    import rand_sched_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_RETRY = DEFAULT_MAX_RETRY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*32-1:0]      req_lo,
    input  logic [N_REQ*32-1:0]      req_hi,
    output logic [N_REQ-1:0]         ack,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);

    localparam int ID_W = id_w(N_REQ);
    localparam int RW   = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]   LAST_TRY = RW'(MAX_RETRY - 1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

    state_t            state_r;
    state_t            state_nx;
    logic [ID_W-1:0]   ptr_r;
    logic [ID_W-1:0]   id_r;
    logic [ID_W-1:0]   grant_idx_s;
    logic [N_REQ-1:0]  grant_s;
    logic [N_REQ-1:0]  ack_r;
    logic [RW-1:0]     retry_r;
    val_t              lo_r;
    val_t              hi_r;
    val_t              rsp_data_r;
    val_t              val_s;
    val_t              lo_arr_s [N_REQ];
    val_t              hi_arr_s [N_REQ];
    logic [31:0]       rng_r;
    logic [31:0]       span_m1_s;
    logic [31:0]       mask_s;
    logic [31:0]       pick_s;
    logic [31:0]       offs_s;
    logic              sat_s;
    logic              capture_s;
    logic              retry_inc_s;
    logic              done_ok_s;
    logic              done_err_s;
    logic              handshake_s;
    logic              rsp_valid_r;
    logic              rsp_err_r;

    for (genvar g = 0; g < N_REQ; g++) begin : g_bounds
        assign lo_arr_s[g] = req_lo[32*g +: 32];
        assign hi_arr_s[g] = req_hi[32*g +: 32];
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_r),
        .enable (state_r == IDLE),
        .grant  (grant_s),
        .idx    (grant_idx_s)
    );

    // Solver: (lo, hi] is empty when lo >= hi; otherwise fold a masked random
    // draw into [0, hi-lo-1] and offset it above lo.
    always_comb begin
        sat_s     = (lo_r < hi_r);
        span_m1_s = hi_r - lo_r - 32'sd1;
        mask_s    = span_mask(span_m1_s);
        pick_s    = rng_r & mask_s;
        if (pick_s > span_m1_s) begin
            offs_s = pick_s - span_m1_s - 32'd1;
        end else begin
            offs_s = pick_s;
        end
        val_s = lo_r + 32'sd1 + $signed(offs_s);
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nx    = state_r;
        capture_s   = 1'b0;
        retry_inc_s = 1'b0;
        done_ok_s   = 1'b0;
        done_err_s  = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (|grant_s) begin
                    capture_s = 1'b1;
                    state_nx  = RAND;
                end else begin
                    state_nx = IDLE;
                end
            end
            RAND: begin
                if (sat_s) begin
                    done_ok_s = 1'b1;
                    state_nx  = RESP;
                end else if (retry_r < LAST_TRY) begin
                    retry_inc_s = 1'b1;
                    state_nx    = RAND;
                end else begin
                    done_err_s = 1'b1;
                    state_nx   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    handshake_s = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    state_nx = RESP;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, bound latches, retry counter, PRNG and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            id_r        <= '0;
            ack_r       <= '0;
            retry_r     <= '0;
            lo_r        <= 32'sd0;
            hi_r        <= 32'sd0;
            rsp_data_r  <= 32'sd0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rng_r       <= RNG_SEED;
        end else begin
            state_r <= state_nx;
            rng_r   <= xorshift32(rng_r);
            ack_r   <= capture_s ? grant_s : '0;
            if (capture_s) begin
                id_r    <= grant_idx_s;
                lo_r    <= lo_arr_s[grant_idx_s];
                hi_r    <= hi_arr_s[grant_idx_s];
                retry_r <= '0;
            end else if (retry_inc_s) begin
                retry_r <= retry_r + 1'b1;
            end else begin
                retry_r <= retry_r;
            end
            if (done_ok_s) begin
                rsp_data_r  <= val_s;
                rsp_err_r   <= 1'b0;
                rsp_valid_r <= 1'b1;
            end else if (done_err_s) begin
                rsp_data_r  <= 32'sd0;
                rsp_err_r   <= 1'b1;
                rsp_valid_r <= 1'b1;
            end else if (handshake_s) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
            if (handshake_s) begin
                ptr_r <= (id_r == LAST_ID) ? '0 : id_r + 1'b1;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign ack       = ack_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_rand_req_sched.sv
// Directed bench for rand_req_sched: reset, single/unsat/boundary bounds,
// signed ranges, backpressure and round-robin fairness with N_REQ=4.
module tb_rand_req_sched;
    import rand_sched_pkg::*;

    localparam int NR = 4;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*32-1:0]  req_lo;
    logic [NR*32-1:0]  req_hi;
    logic [NR-1:0]     ack;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              busy;

    val_t lo_tb [NR];
    val_t hi_tb [NR];
    int   vectors = 0;
    int   miscompares = 0;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign req_lo[32*g +: 32] = lo_tb[g];
        assign req_hi[32*g +: 32] = hi_tb[g];
    end

    rand_req_sched #(
        .N_REQ     (NR),
        .MAX_RETRY (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_lo    (req_lo),
        .req_hi    (req_hi),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from an idle DUT; returns at the cycle rsp_valid rises.
    task automatic run_txn(input logic [1:0] idx, input val_t lo, input val_t hi,
                           output val_t data, output logic err, output logic [1:0] id,
                           output int lat);
        lo_tb[idx] = lo;
        hi_tb[idx] = hi;
        req[idx]   = 1'b1;
        @(negedge clk);
        check("txn_ack", ack, 4'b0001 << idx);
        req[idx]   = 1'b0;
        lo_tb[idx] = 32'sh7FFF_FFFF;
        hi_tb[idx] = 32'sh7FFF_FFFF;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("txn_rsp_valid", rsp_valid, 1'b1);
        data = rsp_data;
        err  = rsp_err;
        id   = rsp_id;
    endtask

    initial begin
        val_t       d;
        val_t       saved;
        logic       e;
        logic [1:0] id;
        logic [1:0] kk;
        logic [4:0] seen;
        int         lat;
        int         bad;
        int         w;

        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req       = '0;
        for (int i = 0; i < NR; i++) begin
            lo_tb[i] = 32'sd0;
            hi_tb[i] = 32'sd0;
        end
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 4'b0000);
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_id", rsp_id, 2'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted while the DUT sits in RAND.
        lo_tb[1] = 32'sd5;
        hi_tb[1] = 32'sd100;
        req[1]   = 1'b1;
        @(negedge clk);
        check("mid_ack", ack, 4'b0010);
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("mid_rst_ack", ack, 4'b0000);
        check("mid_rst_valid", rsp_valid, 1'b0);
        check("mid_rst_id", rsp_id, 2'd0);
        check("mid_rst_data", rsp_data, 32'd0);
        check("mid_rst_err", rsp_err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        rsp_ready = 1'b1;
        run_txn(2'd0, 32'sd5, 32'sd6, d, e, id, lat);
        check("post_rst_data", d, 32'sd6);
        check("post_rst_id", id, 2'd0);
        check("post_rst_err", e, 1'b0);
        @(negedge clk);
        check("post_rst_idle", busy, 1'b0);

        // Single requester, repeated.
        seen = '0;
        for (int k = 0; k < 200; k++) begin
            run_txn(2'd2, 32'sd5, 32'sd10, d, e, id, lat);
            check("single_lat", lat, 2);
            check("single_id", id, 2'd2);
            check("single_err", e, 1'b0);
            check("single_range", (d > 32'sd5 && d <= 32'sd10), 1'b1);
            seen = seen | (5'b00001 << (d - 32'sd6));
            @(negedge clk);
            check("single_drop", rsp_valid, 1'b0);
        end
        check("single_cover", seen, 5'b11111);

        // Unsatisfiable bounds: three RAND cycles then an error response.
        run_txn(2'd0, 32'sd10, 32'sd10, d, e, id, lat);
        check("unsat_eq_lat", lat, 4);
        check("unsat_eq_err", e, 1'b1);
        check("unsat_eq_data", d, 32'sd0);
        check("unsat_eq_id", id, 2'd0);
        @(negedge clk);
        run_txn(2'd0, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, d, e, id, lat);
        check("unsat_max_lat", lat, 4);
        check("unsat_max_err", e, 1'b1);
        check("unsat_max_data", d, 32'sd0);
        @(negedge clk);
        run_txn(2'd1, 32'sd20, -32'sd5, d, e, id, lat);
        check("unsat_inv_lat", lat, 4);
        check("unsat_inv_err", e, 1'b1);
        check("unsat_inv_id", id, 2'd1);
        @(negedge clk);

        // hi = lo + 1 must return exactly hi.
        run_txn(2'd1, 32'sd100, 32'sd101, d, e, id, lat);
        check("unit_pos", d, 32'sd101);
        @(negedge clk);
        run_txn(2'd3, -32'sd2, -32'sd1, d, e, id, lat);
        check("unit_neg", d, -32'sd1);
        @(negedge clk);
        run_txn(2'd3, 32'sh8000_0000, 32'sh8000_0001, d, e, id, lat);
        check("unit_min", d, 32'sh8000_0001);
        @(negedge clk);
        run_txn(2'd0, 32'sh7FFF_FFFE, 32'sh7FFF_FFFF, d, e, id, lat);
        check("unit_max", d, 32'sh7FFF_FFFF);
        check("unit_max_err", e, 1'b0);
        @(negedge clk);

        // Signed bounds.
        for (int k = 0; k < 20; k++) begin
            run_txn(2'd3, -32'sd3, -32'sd1, d, e, id, lat);
            check("signed_range", (d == -32'sd2 || d == -32'sd1), 1'b1);
            check("signed_err", e, 1'b0);
            @(negedge clk);
        end

        // Backpressure with bound changes and a transient request meanwhile.
        rsp_ready = 1'b0;
        run_txn(2'd1, 32'sd0, 32'sd50, d, e, id, lat);
        saved = d;
        check("bp_lat", lat, 2);
        check("bp_range", (d > 32'sd0 && d <= 32'sd50), 1'b1);
        check("bp_id", id, 2'd1);
        for (int k = 0; k < 10; k++) begin
            lo_tb[1] = -32'sd100 - k;
            hi_tb[1] = -32'sd50;
            req[2]   = (k >= 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_data", rsp_data, saved);
            check("bp_id_hold", rsp_id, 2'd1);
            check("bp_err", rsp_err, 1'b0);
            check("bp_busy", busy, 1'b1);
        end
        req[2]    = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_done_valid", rsp_valid, 1'b0);
        check("bp_done_idle", busy, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_late_ack", ack, 4'b0000);
            check("bp_stay_idle", busy, 1'b0);
        end

        // Fairness: all requesters held high from a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) begin
            lo_tb[i] = 32'sd0;
            hi_tb[i] = 32'sd1000;
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            kk = 2'(k);
            w  = 0;
            @(negedge clk);
            while (ack === 4'b0000 && w < 6) begin
                @(negedge clk);
                w++;
            end
            check("fair_ack", ack, 4'b0001 << kk);
            w = 0;
            @(negedge clk);
            while (rsp_valid !== 1'b1 && w < 6) begin
                @(negedge clk);
                w++;
            end
            check("fair_valid", rsp_valid, 1'b1);
            check("fair_id", rsp_id, kk);
            check("fair_err", rsp_err, 1'b0);
        end
        req = '0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rand_req_sched.md
Name: rand_req_sched

Overview:
- Shared constrained-random value server for the randomization feature tests.
- N requesters each ask for a 32-bit signed value constrained to the range (lo, hi].
- A round-robin scheduler grants one requester at a time. It runs `std::randomize(val) with {val > lo; val <= hi;}` on the granted bounds, retries on solver failure, and returns the result over a valid/ready response channel.
- Sits between stimulus-generator blocks and the single randomization resource; there is never more than one randomize call in flight.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- MAX_RETRY, 3, randomize attempts per transaction before reporting an error (>=1)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  N_REQ  per-requester request level, held high until the matching ack
- req_lo  input  N_REQ*32  packed signed lower bounds, exclusive; requester i at [32*i +: 32]
- req_hi  input  N_REQ*32  packed signed upper bounds, inclusive
- ack  output  N_REQ  one-hot, one-cycle pulse when the request is captured
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  $clog2(N_REQ)  index of the requester served
- rsp_data  output  32  signed random value; 0 when rsp_err=1
- rsp_err  output  1  all MAX_RETRY attempts failed
- busy  output  1  high in every state other than IDLE

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; ack=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
  - Round-robin pointer=0, retry count=0.
  - Any in-flight transaction is dropped with no response, and no ack is replayed.
- FSM states: IDLE, RAND, RESP.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the pointer, wrapping.
  - Latch its lo/hi and id, pulse ack[id] for exactly one cycle, clear the retry count, go to RAND.
- RAND, one randomize attempt per cycle using the latched bounds (changes on req_lo/req_hi after capture are ignored):
  - success: latch val into rsp_data, rsp_err=0, go to RESP.
  - failure with retry count < MAX_RETRY-1: increment the count, stay in RAND.
  - failure on the last attempt: rsp_data=0, rsp_err=1, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err stay stable until rsp_ready is sampled high.
  - On the handshake: rsp_valid=0 next cycle, pointer=(id+1) mod N_REQ, go to IDLE.
- Latency:
  - req high in IDLE at cycle 0 gives ack at cycle 1, RAND at cycle 1, and rsp_valid at cycle 2 on first-try success.
  - Each failed attempt adds one cycle.
  - At most one transaction every 3 cycles.
- Constraint semantics:
  - Signed 32-bit comparison.
  - lo >= hi, or lo = 32'h7FFFFFFF, is unsatisfiable. The solver must fail, giving exactly MAX_RETRY RAND cycles and then rsp_err=1.
  - hi = lo+1 must return exactly hi.
- Simultaneous requests are served one at a time in rotating order; no requester is starved beyond N_REQ-1 other transactions.
- A req that drops before its ack is simply not served.
- A req held high after its ack is treated as a new request.
- A new req arriving during RAND/RESP waits; it is sampled only in IDLE.
- busy equals (state != IDLE).

Decomposition:
- Package rand_sched_pkg:
  - state enum (IDLE, RAND, RESP);
  - typedef val_t as signed 32-bit;
  - constant DEFAULT_MAX_RETRY=3;
  - function id_w(n) returning max(1, $clog2(n)).
- Sub-module rr_arbiter:
  - parameters N;
  - inputs req, ptr, enable; output one-hot grant and encoded index;
  - purely combinational priority rotation, so it can be reused by other schedulers.
- rand_req_sched owns the FSM, bound latches, retry counter, randomize call and response register.

Test Plan:
- Reset mid-RAND:
  - Stimulus: req[1] with lo=5, hi=100; assert rst_n=0 while in RAND.
  - Required: all outputs 0 immediately; no rsp_valid after release.
  - Then req[0] with lo=5, hi=6 → rsp_data=6, rsp_id=0.
- Single requester:
  - Stimulus: req[2] with lo=5, hi=10, rsp_ready=1.
  - Required: ack=4'b0100 at cycle 1, rsp_valid at cycle 2, rsp_id=2, 6<=rsp_data<=10, rsp_err=0.
  - Repeat 200 times: every value satisfies the constraint, and every value 6..10 is observed.
- Unsatisfiable:
  - Stimulus: req[0] with lo=10, hi=10, MAX_RETRY=3.
  - Required: exactly 3 RAND cycles, then rsp_valid with rsp_err=1, rsp_data=0.
  - Same result for lo=32'h7FFFFFFF.
- Fairness:
  - Stimulus: all 4 req held high continuously, rsp_ready=1.
  - Required: rsp_id sequence 0,1,2,3,0,1,...; ack one-hot each time.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid; change req_lo/req_hi meanwhile.
  - Required: rsp_valid, rsp_data and rsp_id stable throughout; handshake on rsp_ready=1; IDLE the next cycle.
- Signed bounds:
  - Stimulus: lo=-3, hi=-1.
  - Required: rsp_data in {-2,-1}.
